// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUControl operation codes and the serial executor FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Subtract and set-less-than both compute A + ~B + 1.
  function automatic logic uses_inv_b(input logic [2:0] ctrl);
    return (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// Combinational DIGIT-wide ALU slice: add/sub/slt via a carry chain, and/or bitwise.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             carry_in,
  input  logic [2:0]       ctrl,
  output logic [DIGIT-1:0] y,
  output logic             carry_out
);

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT:0]   sum;

  always_comb begin
    b_eff     = uses_inv_b(ctrl) ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_in};
    y         = '0;
    carry_out = 1'b0;
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_SLT: begin
        y         = sum[DIGIT-1:0];
        carry_out = sum[DIGIT];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_exec.sv
// Digit-serial ALU: accepts a job, processes DIGIT bits per cycle over N cycles,
// then presents ALUResult/Zero on a valid/ready result handshake.
module alu_serial_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("alu_serial_exec: WIDTH must be a non-zero multiple of DIGIT");
  end

  alu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             res_valid_q, res_valid_d;
  logic             start_ready_q, start_ready_d;

  logic [DIGIT-1:0] dig_y;
  logic             dig_co;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] final_res;
  logic             lt;

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .carry_in (carry_q),
    .ctrl     (ctrl_q),
    .y        (dig_y),
    .carry_out(dig_co)
  );

  // Operands shift right one digit per cycle and results shift in from the top,
  // so the slice always sees bits [DIGIT-1:0]; no cnt*DIGIT indexing is needed.
  if (N == 1) begin : g_one_digit
    assign part_next = dig_y;
  end else begin : g_multi_digit
    assign part_next = {dig_y, part_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    a_d           = a_q;
    b_d           = b_q;
    ctrl_d        = ctrl_q;
    part_d        = part_q;
    result_d      = result_q;
    zero_d        = zero_q;
    res_valid_d   = res_valid_q;
    start_ready_d = start_ready_q;

    // On the last digit the operand low bits hold the original sign bits.
    lt = (a_q[DIGIT-1] != b_q[DIGIT-1]) ? a_q[DIGIT-1] : dig_y[DIGIT-1];
    case (ctrl_q)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR: final_res = part_next;
      ALU_SLT:                           final_res = WIDTH'(lt);
      default:                           final_res = '0;
    endcase

    case (state_q)
      IDLE: begin
        if (start_valid && start_ready_q) begin
          a_d           = SrcA;
          b_d           = SrcB;
          ctrl_d        = ALUControl;
          cnt_d         = '0;
          carry_d       = uses_inv_b(ALUControl);
          start_ready_d = 1'b0;
          state_d       = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        part_d  = part_next;
        carry_d = dig_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          result_d    = final_res;
          zero_d      = (final_res == '0);
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d   = 1'b0;
          start_ready_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        res_valid_d   = 1'b0;
        start_ready_d = 1'b1;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      ctrl_q        <= '0;
      part_q        <= '0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      a_q           <= a_d;
      b_q           <= b_d;
      ctrl_q        <= ctrl_d;
      part_q        <= part_d;
      result_q      <= result_d;
      zero_q        <= zero_d;
      res_valid_q   <= res_valid_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign ALUResult   = result_q;
  assign Zero        = zero_q;

endmodule

// File: tb/tb_alu_serial_exec.sv
// Scoreboard bench for alu_serial_exec: driver pushes expected results, a negedge monitor checks them.
module tb_alu_serial_exec;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int D    = 8;
  localparam int NDIG = W / D;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_valid;
  logic         start_ready;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] ALUResult;
  logic         Zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  logic [W-1:0] last_res  = '0;
  logic         last_zero = 1'b0;
  bit           prev_valid = 1'b0;

  alu_serial_exec #(.WIDTH(W), .DIGIT(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    case (c)
      3'b000:  e.res = a + b;
      3'b001:  e.res = a - b;
      3'b010:  e.res = a & b;
      3'b011:  e.res = a | b;
      3'b101:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_result", ALUResult, 32'd0);
      check("rst_zero", 32'(Zero), 32'd0);
      check("rst_start_ready", 32'(start_ready), 32'd1);
      last_res   = '0;
      last_zero  = 1'b0;
      prev_valid = 1'b0;
    end else if (res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=0x%08h required=no_result_pending", ALUResult);
      end else begin
        if (!prev_valid) check("latency", 32'(cyc - acc_q[0]), 32'(NDIG));
        check("result", ALUResult, exp_q[0].res);
        check("zero", 32'(Zero), 32'(exp_q[0].zero));
        check("start_ready_in_done", 32'(start_ready), 32'd0);
        if (res_ready) begin
          last_res  = exp_q[0].res;
          last_zero = exp_q[0].zero;
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      prev_valid = !res_ready;
    end else begin
      check("hold_result", ALUResult, last_res);
      check("hold_zero", 32'(Zero), 32'(last_zero));
      prev_valid = 1'b0;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge (or after toggling).
  task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit toggle, input bit track);
    int unsigned guard = 0;
    while (!start_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!start_ready) begin
      checks++;
      failures++;
      $display("FAIL start_ready_timeout actual=0 required=1");
      return;
    end
    start_valid = 1'b1;
    ALUControl  = c;
    SrcA        = a;
    SrcB        = b;
    @(posedge clk); #1;
    if (track) begin
      acc_q.push_back(cyc);
      exp_q.push_back(model(c, a, b));
    end
    start_valid = 1'b0;
    check("ready_low_after_accept", 32'(start_ready), 32'd0);
    if (toggle) begin
      for (int i = 0; i < NDIG; i++) begin
        ALUControl = 3'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    while ((exp_q.size() != 0 || !start_ready) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0 || !start_ready) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0_pending", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]   ctrl_tab [11];
    logic [W-1:0] corner   [4];
    logic [W-1:0] ra, rb;
    int           hs_cyc;

    ctrl_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b000, 3'b001, 3'b101, 3'b111, 3'b100, 3'b110};
    corner   = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    reset_n     = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    ALUControl  = '0;
    SrcA        = '0;
    SrcB        = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    issue(ALU_ADD, 32'd5, 32'd7, 0, 1);
    issue(ALU_SUB, 32'h0000_0100, 32'd1, 0, 1);
    issue(ALU_SUB, 32'd7, 32'd7, 0, 1);
    issue(ALU_SLT, 32'hFFFF_FFFB, 32'd3, 0, 1);
    issue(ALU_SLT, 32'd3, 32'hFFFF_FFFB, 0, 1);
    issue(ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1);
    issue(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1);
    issue(ALU_SLT, 32'h1234_5678, 32'h1234_5678, 0, 1);
    issue(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1);
    issue(ALU_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1);
    issue(3'b111,  32'hDEAD_BEEF, 32'h1234_5678, 0, 1);
    wait_idle();

    // Backpressure with an ignored start pulse while the result is pending.
    res_ready = 1'b0;
    issue(ALU_ADD, 32'hDEAD_BEEF, 32'h1111_1111, 0, 1);
    for (int g = 0; g < 20 && !res_valid; g++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      if (k == 2) begin
        start_valid = 1'b1;
        ALUControl  = ALU_SUB;
        SrcA        = 32'h0BAD_F00D;
        SrcB        = 32'h0000_0001;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    hs_cyc = cyc;
    check("ready_after_handshake", 32'(start_ready), 32'd1);
    issue(ALU_OR, 32'h0000_00A0, 32'h0000_000B, 0, 1);
    check("next_accept_cycle", 32'(acc_q[$] - hs_cyc), 32'd1);
    wait_idle();

    // Operands toggled during RUN must not affect the latched job.
    for (int j = 0; j < 4; j++) begin
      issue(ctrl_tab[$urandom_range(0, 10)], $urandom, $urandom, 1, 1);
    end
    wait_idle();

    // Reset at cnt=2 aborts the job.
    issue(ALU_ADD, 32'h0000_FFFF, 32'h0000_0001, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrun_rst_valid", 32'(res_valid), 32'd0);
    check("midrun_rst_result", ALUResult, 32'd0);
    check("midrun_rst_start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(ALU_ADD, 32'd1, 32'd1, 0, 1);
    wait_idle();

    for (int j = 0; j < 40; j++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 300); rb = $urandom_range(0, 300); end
        2: begin ra = corner[$urandom_range(0, 3)]; rb = corner[$urandom_range(0, 3)]; end
        default: begin ra = $urandom; rb = ra; end
      endcase
      issue(ctrl_tab[$urandom_range(0, 10)], ra, rb, bit'($urandom_range(0, 1)), 1);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
